// File: rtl/snoopy_axis_motion.sv
// Single-axis sprite motion controller: buttons -> signed speed (accel/brake/cap) -> bounded position.
// Define SNOOPY_AXIS_WRAP_EN to wrap position at the bounds instead of clamping.
module snoopy_axis_motion #(
    parameter int POS_W     = 8,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 160,
    parameter int POS_INIT  = 0,
    parameter int SPEED_W   = 4,
    parameter int MAX_SPEED = 4,
    parameter int ACCEL     = 1,
    parameter int DECEL     = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               tick,
    input  logic               move_neg,
    input  logic               move_pos,
    output logic [POS_W-1:0]   pos,
    output logic [SPEED_W-1:0] speed,
    output logic [1:0]         state_o,
    output logic               at_min,
    output logic               at_max
);

    localparam int SUM_W = ((POS_W > SPEED_W) ? POS_W : SPEED_W) + 2;
    localparam int FIRST = (ACCEL < MAX_SPEED) ? ACCEL : MAX_SPEED;
    localparam logic signed [SUM_W-1:0] POS_MIN_S = SUM_W'(POS_MIN);
    localparam logic signed [SUM_W-1:0] POS_MAX_S = SUM_W'(POS_MAX);
`ifdef SNOOPY_AXIS_WRAP_EN
    localparam logic signed [SUM_W-1:0] SPAN_S    = SUM_W'(POS_MAX - POS_MIN + 1);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MOVE_NEG = 2'b01,
        MOVE_POS = 2'b10,
        BRAKE    = 2'b11
    } state_t;

    state_t                     state_q, state_d, fsm_state;
    logic [POS_W-1:0]           pos_q, pos_d;
    logic signed [SPEED_W-1:0]  speed_q, speed_d, fsm_speed;
    logic signed [SPEED_W-1:0]  neg_speed, mag_s;
    logic [SPEED_W-1:0]         mag, mag_up, mag_dn, fsm_mag;
    logic                       dir_pos, dir_neg, spd_neg, fsm_neg;
    logic signed [SUM_W-1:0]    pos_ext, spd_ext, sum;

    function automatic logic [SPEED_W-1:0] mag_inc(input logic [SPEED_W-1:0] m);
        int t;
        t = int'(m) + ACCEL;
        if (t > MAX_SPEED) t = MAX_SPEED;
        return t[SPEED_W-1:0];
    endfunction

    function automatic logic [SPEED_W-1:0] mag_dec(input logic [SPEED_W-1:0] m);
        int t;
        t = int'(m) - DECEL;
        if (t < 0) t = 0;
        return t[SPEED_W-1:0];
    endfunction

    always_comb begin
        dir_pos   = move_pos & ~move_neg;
        dir_neg   = move_neg & ~move_pos;
        spd_neg   = speed_q[SPEED_W-1];
        neg_speed = -speed_q;
        mag       = spd_neg ? neg_speed : speed_q;
        mag_up    = mag_inc(mag);
        mag_dn    = mag_dec(mag);

        fsm_state = state_q;
        fsm_mag   = mag;
        fsm_neg   = spd_neg;
        case (state_q)
            IDLE: begin
                fsm_mag = '0;
                fsm_neg = 1'b0;
                if (dir_pos) begin
                    fsm_state = MOVE_POS;
                    fsm_mag   = SPEED_W'(FIRST);
                end else if (dir_neg) begin
                    fsm_state = MOVE_NEG;
                    fsm_mag   = SPEED_W'(FIRST);
                    fsm_neg   = 1'b1;
                end
            end
            MOVE_POS, MOVE_NEG: begin
                fsm_neg = (state_q == MOVE_NEG);
                if (fsm_neg ? dir_neg : dir_pos) begin
                    fsm_mag = mag_up;
                end else begin
                    // Any other input brakes; reversal must pass through BRAKE
                    fsm_mag   = mag_dn;
                    fsm_state = (mag_dn == '0) ? IDLE : BRAKE;
                end
            end
            BRAKE: begin
                if (spd_neg ? dir_neg : dir_pos) begin
                    fsm_mag   = mag_up;
                    fsm_state = spd_neg ? MOVE_NEG : MOVE_POS;
                end else begin
                    fsm_mag   = mag_dn;
                    fsm_state = (mag_dn == '0) ? IDLE : BRAKE;
                end
            end
            default: ;
        endcase
        mag_s     = fsm_mag;
        fsm_speed = fsm_neg ? -mag_s : mag_s;

        // Position integrates the speed held before this tick
        pos_ext = $signed({{(SUM_W-POS_W){1'b0}}, pos_q});
        spd_ext = {{(SUM_W-SPEED_W){speed_q[SPEED_W-1]}}, speed_q};
        sum     = pos_ext + spd_ext;

        pos_d   = POS_W'(sum);
        speed_d = fsm_speed;
        state_d = fsm_state;
`ifdef SNOOPY_AXIS_WRAP_EN
        if (sum > POS_MAX_S) begin
            pos_d = POS_W'(sum - SPAN_S);
        end else if (sum < POS_MIN_S) begin
            pos_d = POS_W'(sum + SPAN_S);
        end
`else
        if (sum > POS_MAX_S) begin
            pos_d   = POS_W'(POS_MAX);
            speed_d = '0;
            state_d = IDLE;
        end else if (sum < POS_MIN_S) begin
            pos_d   = POS_W'(POS_MIN);
            speed_d = '0;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos_q   <= POS_W'(POS_INIT);
            speed_q <= '0;
            state_q <= IDLE;
        end else if (tick) begin
            pos_q   <= pos_d;
            speed_q <= speed_d;
            state_q <= state_d;
        end
    end

    assign pos     = pos_q;
    assign speed   = speed_q;
    assign state_o = state_q;
    assign at_min  = (pos_q == POS_W'(POS_MIN));
    assign at_max  = (pos_q == POS_W'(POS_MAX));

endmodule

// File: tb/tb_snoopy_axis_motion.sv
// Scoreboard bench for snoopy_axis_motion: directed scenarios plus randomized button/tick traffic.
module tb_snoopy_axis_motion;

    localparam int POS_W     = 8;
    localparam int POS_MIN   = 0;
    localparam int POS_MAX   = 160;
    localparam int POS_INIT  = 0;
    localparam int SPEED_W   = 4;
    localparam int MAX_SPEED = 4;
    localparam int ACCEL     = 1;
    localparam int DECEL     = 1;
    localparam int SPAN      = POS_MAX - POS_MIN + 1;

    logic               clock;
    logic               resetn;
    logic               tick;
    logic               move_neg;
    logic               move_pos;
    logic [POS_W-1:0]   pos;
    logic [SPEED_W-1:0] speed;
    logic [1:0]         state_o;
    logic               at_min;
    logic               at_max;

    snoopy_axis_motion #(
        .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL), .DECEL(DECEL)
    ) dut (
        .clock(clock), .resetn(resetn), .tick(tick),
        .move_neg(move_neg), .move_pos(move_pos),
        .pos(pos), .speed(speed), .state_o(state_o),
        .at_min(at_min), .at_max(at_max)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int pos;
        int spd;
        int st;
        int tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: plain integers, state coded 0 idle, 1 neg, 2 pos, 3 brake
    int m_pos, m_spd, m_st;

    int t2p[6]  = '{0, 1, 3, 6, 10, 14};
    int t2s[6]  = '{1, 2, 3, 4, 4, 4};
    int t3p[4]  = '{18, 21, 23, 24};
    int t3s[4]  = '{3, 2, 1, 0};
    int t3st[4] = '{3, 3, 3, 0};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_pos = POS_INIT;
        m_spd = 0;
        m_st  = 0;
    endtask

    task automatic model_step(input logic t, input logic mn, input logic mp);
        int dir, nxt, mag, sg, nm, ns, nst;
        if (!t) return;
        dir = (mp && !mn) ? 1 : ((mn && !mp) ? -1 : 0);
        nxt = m_pos + m_spd;
        mag = (m_spd < 0) ? -m_spd : m_spd;
        sg  = (m_spd < 0) ? -1 : 1;
        ns  = m_spd;
        nst = m_st;
        if (m_st == 0) begin
            if (dir != 0) begin
                ns  = dir * imin(ACCEL, MAX_SPEED);
                nst = (dir > 0) ? 2 : 1;
            end else begin
                ns = 0;
            end
        end else begin
            if (m_st != 3) sg = (m_st == 2) ? 1 : -1;
            if (dir == sg) begin
                nm  = imin(mag + ACCEL, MAX_SPEED);
                nst = (sg > 0) ? 2 : 1;
            end else begin
                nm  = imax(mag - DECEL, 0);
                nst = (nm == 0) ? 0 : 3;
            end
            ns = sg * nm;
        end
`ifdef SNOOPY_AXIS_WRAP_EN
        if (nxt > POS_MAX) nxt = nxt - SPAN;
        else if (nxt < POS_MIN) nxt = nxt + SPAN;
`else
        if (nxt > POS_MAX) begin
            nxt = POS_MAX; ns = 0; nst = 0;
        end else if (nxt < POS_MIN) begin
            nxt = POS_MIN; ns = 0; nst = 0;
        end
`endif
        m_pos = nxt;
        m_spd = ns;
        m_st  = nst;
    endtask

    task automatic check(input exp_t e);
        int   ap, as, ast;
        logic emin, emax;
        ap   = int'(pos);
        as   = int'($signed(speed));
        ast  = int'(state_o);
        emin = (e.pos == POS_MIN);
        emax = (e.pos == POS_MAX);
        n_vec++;
        if (ap != e.pos || as != e.spd || ast != e.st || at_min !== emin || at_max !== emax) begin
            n_err++;
            $display("FAIL test%0d t=%0t: got pos=%0d speed=%0d state=%0d at_min=%b at_max=%b, want pos=%0d speed=%0d state=%0d at_min=%b at_max=%b",
                     e.tag, $time, ap, as, ast, at_min, at_max, e.pos, e.spd, e.st, emin, emax);
        end
    endtask

    task automatic drive_model(input int tag, input logic t, input logic mn, input logic mp);
        @(negedge clock);
        tick = t; move_neg = mn; move_pos = mp;
        model_step(t, mn, mp);
        q.push_back('{m_pos, m_spd, m_st, tag});
    endtask

    task automatic drive_const(input int tag, input logic t, input logic mn, input logic mp,
                               input int p, input int s, input int st);
        @(negedge clock);
        tick = t; move_neg = mn; move_pos = mp;
        model_step(t, mn, mp);
        q.push_back('{p, s, st, tag});
    endtask

    task automatic bound_fail(input int tag);
        n_vec++;
        n_err++;
        $display("FAIL test%0d setup: model never reached target state (pos=%0d speed=%0d)", tag, m_pos, m_spd);
    endtask

    task automatic brake_to_idle(input int tag);
        for (int k = 0; k < 20 && m_st != 0; k++) drive_model(tag, 1'b1, 1'b0, 1'b0);
        if (m_st != 0) bound_fail(tag);
    endtask

    initial begin
        logic rn, rp;
        resetn = 1'b0; tick = 1'b0; move_neg = 1'b0; move_pos = 1'b0;
        model_reset();
        #12;
        check('{POS_INIT, 0, 0, 0});
        @(negedge clock);
        resetn = 1'b1;

        fork
            forever begin
                @(posedge clock);
                #1;
                if (q.size() > 0) check(q.pop_front());
            end
        join_none

        // Acceleration up to the cap, then coasting down through BRAKE
        for (int i = 0; i < 6; i++) drive_const(2, 1'b1, 1'b0, 1'b1, t2p[i], t2s[i], 2);
        for (int i = 0; i < 4; i++) drive_const(3, 1'b1, 1'b0, 1'b0, t3p[i], t3s[i], t3st[i]);

        // Run into the upper wall from pos=158 at full speed
        for (int k = 0; k < 200 && !(m_pos == POS_MAX - 2 && m_spd == MAX_SPEED); k++)
            drive_model(4, 1'b1, 1'b0, 1'b1);
        if (!(m_pos == POS_MAX - 2 && m_spd == MAX_SPEED)) bound_fail(4);
`ifdef SNOOPY_AXIS_WRAP_EN
        drive_const(6, 1'b1, 1'b0, 1'b1, 1, 4, 2);
        drive_const(6, 1'b1, 1'b0, 1'b1, 5, 4, 2);
        drive_const(6, 1'b1, 1'b0, 1'b1, 9, 4, 2);
`else
        drive_const(4, 1'b1, 1'b0, 1'b1, 160, 0, 0);
        drive_const(4, 1'b1, 1'b0, 1'b1, 160, 1, 2);
        drive_const(4, 1'b1, 1'b0, 1'b1, 160, 0, 0);
`endif

        // Back away from the wall, then the no-op and reversal scenarios
        for (int i = 0; i < 10; i++) drive_model(5, 1'b1, 1'b1, 1'b0);
        brake_to_idle(5);
        for (int i = 0; i < 3; i++) drive_model(5, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_model(5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive_model(5, 1'b1, 1'b0, 1'b1);
        drive_const(5, 1'b1, 1'b1, 1'b0, m_pos + 2, 1, 3);
        drive_const(5, 1'b1, 1'b1, 1'b0, m_pos + 1, 0, 0);

        // Asynchronous reset between clock edges while moving
        brake_to_idle(1);
        for (int i = 0; i < 3; i++) drive_model(1, 1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #2;
        tick = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        check('{POS_INIT, 0, 0, 1});
        resetn = 1'b1;

        // Randomized traffic with sticky buttons so motion builds up
        rn = 1'b0; rp = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rn = 1'($urandom_range(0, 1));
                rp = 1'($urandom_range(0, 1));
            end
            drive_model(7, 1'($urandom_range(0, 1)), rn, rp);
        end
        drive_model(7, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clock);
        #2;
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snoopy_axis_motion.md
Name: snoopy_axis_motion

Overview:
- Parametrised single-axis motion controller for the Snoopy sprite; one instance per axis (horizontal and vertical).
- Converts two direction buttons into a signed speed with acceleration, braking and a speed cap.
- Integrates speed into a bounded position, once per frame tick, for the VGA draw logic.
- Successor to the fixed-width, fixed-speed ±1 horizontal controller.

Parameters:
POS_W, 8, position width (unsigned)
POS_MIN, 0, lowest legal position
POS_MAX, 160, highest legal position; must be < 2^POS_W and > POS_MIN
POS_INIT, 0, position after reset
SPEED_W, 4, speed width (two's complement)
MAX_SPEED, 4, speed magnitude cap; must be < 2^(SPEED_W-1)
ACCEL, 1, speed magnitude added per tick while driving
DECEL, 1, speed magnitude removed per tick while braking

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous, active-low reset
tick  in  1  frame-rate enable, one clock wide; all state updates occur only when tick=1
move_neg  in  1  drive toward POS_MIN (left/up)
move_pos  in  1  drive toward POS_MAX (right/down)
pos  out  POS_W  current position
speed  out  SPEED_W  current signed speed
state_o  out  2  IDLE=00, MOVE_NEG=01, MOVE_POS=10, BRAKE=11
at_min  out  1  pos==POS_MIN (combinational from pos)
at_max  out  1  pos==POS_MAX (combinational from pos)

Behaviour:
- Reset: resetn low asynchronously forces pos=POS_INIT, speed=0, state=IDLE, independent of clock and tick. Deassertion is used synchronously.
- tick=0: every register holds; button inputs are ignored.
- Direction decode, sampled on tick:
  - dir=-1 when only move_neg is high.
  - dir=+1 when only move_pos is high.
  - dir=0 when both or neither are high.
- Position update uses the registered speed from before this tick: pos_next = pos + speed.
  - Computed signed, at width max(POS_W,SPEED_W)+2, with no overflow.
  - One tick of latency from a speed change to its effect on position.
- IDLE:
  - dir=+1 -> MOVE_POS, speed=+min(ACCEL,MAX_SPEED).
  - dir=-1 -> MOVE_NEG, speed=-min(ACCEL,MAX_SPEED).
  - dir=0 -> stay in IDLE, speed=0.
- MOVE_POS / MOVE_NEG:
  - dir equal to the motion sign -> |speed| = min(|speed|+ACCEL, MAX_SPEED).
  - dir=0 or dir opposite to the motion sign -> BRAKE, |speed| = max(|speed|-DECEL, 0).
  - Reversal is never instantaneous; the controller always passes through BRAKE.
- BRAKE:
  - dir equal to the sign of speed -> return to the matching MOVE state, |speed| += ACCEL (capped at MAX_SPEED).
  - Otherwise |speed| = max(|speed|-DECEL, 0).
  - When the resulting speed is 0 -> IDLE in the same tick.
- Bounds (clamp mode), which override the FSM result for that tick:
  - pos_next > POS_MAX -> pos=POS_MAX, speed=0, state=IDLE.
  - pos_next < POS_MIN -> pos=POS_MIN, speed=0, state=IDLE.
  - Landing exactly on a bound does not clamp.
  - Pushing into a wall therefore alternates between IDLE (speed 0) and MOVE (speed ±ACCEL) while pos stays at the bound. This is required behaviour.
- Speed sign always matches state: positive in MOVE_POS, negative in MOVE_NEG, zero in IDLE, nonzero in BRAKE.

Optional Feature:
- Macro: SNOOPY_AXIS_WRAP_EN.
- Defined: bounds wrap instead of clamp, with span = POS_MAX-POS_MIN+1.
  - pos_next > POS_MAX -> pos = pos_next - span.
  - pos_next < POS_MIN -> pos = pos_next + span.
  - Speed and state are unaffected by wrapping.
  - Requires MAX_SPEED <= span.
- Undefined: clamp behaviour as specified above.

Test Plan:
1. Pulse resetn low mid-motion (pos=50, speed=3) between clock edges -> pos=0, speed=0, state_o=00 immediately, with no clock edge needed.
2. From pos=0, hold move_pos for 6 ticks -> speed 1,2,3,4,4,4; pos 0,1,3,6,10,14; state_o=10 throughout.
3. Release at pos=14, speed=4 -> state 11 with speed 3,2,1 and pos 18,21,23; fourth tick gives speed 0, state 00, pos 24.
4. At pos=158, speed=+4, move_pos held -> pos=160, speed=0, IDLE, at_max=1. Next tick: speed=1, MOVE_POS, pos=160. Following tick: clamps again to pos=160, IDLE.
5. From IDLE, both buttons high for 3 ticks -> no change. Then move_pos high with tick=0 for 10 clocks -> no change. Then speed=+2 in MOVE_POS, press move_neg -> BRAKE with speed 1, then IDLE; never reaches MOVE_NEG before speed reaches 0.
6. With SNOOPY_AXIS_WRAP_EN, at pos=158, speed=+4, move_pos held -> pos=1, speed=4, state MOVE_POS.
